cosim_log_item_assembler: RTL and testbench

//  Rebuilds commit-log items (register writes, memory reads, memory writes) from DPI_W-bit words.
//  The words are streamed out of the DPI import layer, one word per handshake.

---
 rtl/cosim_log_item_assembler.sv | 201 ++++++++++++++++++++
 tb/tb_cosim_log_item_assembler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_log_item_assembler.sv
// Rebuilds DPI word streams into commit-log records and buffers them in a small FIFO.
// Word counts are derived from XREG_W/FREG_W/DPI_W; framing errors pulse err_o.
module cosim_log_item_assembler #(
    parameter int XREG_W     = 64,
    parameter int FREG_W     = 128,
    parameter int DPI_W      = 32,
    parameter int DEPTH      = 4,
    parameter int KEY_TYPE_W = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         in_sof_i,
    input  logic [1:0]                   in_kind_i,
    input  logic [DPI_W-1:0]             in_word_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [1:0]                   out_kind_o,
    output logic [KEY_TYPE_W-1:0]        out_key_type_o,
    output logic [XREG_W-KEY_TYPE_W-1:0] out_key_id_o,
    output logic [XREG_W-1:0]            out_addr_o,
    output logic [FREG_W-1:0]            out_data_o,
    output logic [DPI_W-1:0]             out_size_o,
    output logic                         err_o,
    output logic [31:0]                  item_cnt_o
);

    localparam int XW        = XREG_W / DPI_W;
    localparam int FW        = FREG_W / DPI_W;
    localparam int REG_WORDS = XW + FW;
    localparam int MEM_WORDS = 2 * XW + 1;
    localparam int MAX_WORDS = (REG_WORDS > MEM_WORDS) ? REG_WORDS : MEM_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS + 1);
    localparam int PTR_W     = $clog2(DEPTH);

    localparam logic [1:0] KIND_REG = 2'd0;
    localparam logic [1:0] KIND_ILL = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DROP} state_t;

    typedef struct packed {
        logic [1:0]                   kind;
        logic [KEY_TYPE_W-1:0]        key_type;
        logic [XREG_W-KEY_TYPE_W-1:0] key_id;
        logic [XREG_W-1:0]            addr;
        logic [FREG_W-1:0]            data;
        logic [DPI_W-1:0]             size;
    } rec_t;

    state_t                       state_q, state_n;
    logic [CNT_W-1:0]             cnt_q, cnt_n, last_idx;
    logic [1:0]                   kind_q, kind_n;
    logic [XW-1:0][DPI_W-1:0]     key_q, key_n, addr_q, addr_n, mdat_q, mdat_n;
    logic [FW-1:0][DPI_W-1:0]     val_q, val_n;
    logic [DPI_W-1:0]             size_q, size_n;
    logic                         err_q, err_n;
    logic                         push, pop, accept;
    logic [31:0]                  item_cnt_q;
    rec_t                         push_rec, head;

    rec_t                         mem [DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]               count_q;

    assign in_ready_o = (count_q != (PTR_W+1)'(DEPTH));
    assign accept     = in_valid_i & in_ready_o;
    assign last_idx   = (kind_q == KIND_REG) ? CNT_W'(REG_WORDS - 1) : CNT_W'(MEM_WORDS - 1);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        kind_n  = kind_q;
        key_n   = key_q;
        val_n   = val_q;
        addr_n  = addr_q;
        mdat_n  = mdat_q;
        size_n  = size_q;
        err_n   = 1'b0;
        push    = 1'b0;
        if (accept) begin
            if (in_sof_i) begin
                // A sof always restarts framing; a truncated item in COLLECT is an error.
                if (state_q == ST_COLLECT) err_n = 1'b1;
                if (in_kind_i == KIND_ILL) begin
                    state_n = ST_DROP;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                end else begin
                    state_n = ST_COLLECT;
                    cnt_n   = CNT_W'(1);
                    kind_n  = in_kind_i;
                    key_n   = '0;
                    val_n   = '0;
                    addr_n  = '0;
                    mdat_n  = '0;
                    size_n  = '0;
                    if (in_kind_i == KIND_REG) key_n[0] = in_word_i;
                    else                       addr_n[0] = in_word_i;
                end
            end else begin
                case (state_q)
                    ST_IDLE: err_n = 1'b1;
                    ST_COLLECT: begin
                        if (kind_q == KIND_REG) begin
                            for (int unsigned i = 0; i < XW; i++)
                                if (cnt_q == CNT_W'(i)) key_n[i] = in_word_i;
                            for (int unsigned i = 0; i < FW; i++)
                                if (cnt_q == CNT_W'(XW + i)) val_n[i] = in_word_i;
                        end else begin
                            for (int unsigned i = 0; i < XW; i++) begin
                                if (cnt_q == CNT_W'(i))      addr_n[i] = in_word_i;
                                if (cnt_q == CNT_W'(XW + i)) mdat_n[i] = in_word_i;
                            end
                            if (cnt_q == CNT_W'(2 * XW)) size_n = in_word_i;
                        end
                        if (cnt_q == last_idx) begin
                            push    = 1'b1;
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_q + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Record is built from the next-field values so the last word lands in the same push.
    always_comb begin
        push_rec      = '0;
        push_rec.kind = kind_q;
        if (kind_q == KIND_REG) begin
            {push_rec.key_type, push_rec.key_id} = key_n;
            push_rec.data                        = val_n;
        end else begin
            push_rec.addr = addr_n;
            push_rec.data = FREG_W'(mdat_n);
            push_rec.size = size_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            kind_q     <= '0;
            key_q      <= '0;
            val_q      <= '0;
            addr_q     <= '0;
            mdat_q     <= '0;
            size_q     <= '0;
            err_q      <= 1'b0;
            item_cnt_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            kind_q  <= kind_n;
            key_q   <= key_n;
            val_q   <= val_n;
            addr_q  <= addr_n;
            mdat_q  <= mdat_n;
            size_q  <= size_n;
            err_q   <= err_n;
            if (push) item_cnt_q <= item_cnt_q + 32'd1;
        end
    end

    assign pop = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
            else if (pop && !push) count_q <= count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= push_rec;
    end

    assign out_valid_o    = (count_q != '0);
    assign head           = out_valid_o ? mem[rd_ptr_q] : '0;
    assign out_kind_o     = head.kind;
    assign out_key_type_o = head.key_type;
    assign out_key_id_o   = head.key_id;
    assign out_addr_o     = head.addr;
    assign out_data_o     = head.data;
    assign out_size_o     = head.size;
    assign err_o          = err_q;
    assign item_cnt_o     = item_cnt_q;

endmodule

// File: tb/tb_cosim_log_item_assembler.sv
// Directed bench for cosim_log_item_assembler with default parameters
// (REG items 6 words, MEM items 5 words, 4-entry FIFO).
module tb_cosim_log_item_assembler;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i, in_sof_i, out_ready_i;
    logic [1:0]   in_kind_i;
    logic [31:0]  in_word_i;
    logic         in_ready_o, out_valid_o, err_o;
    logic [1:0]   out_kind_o;
    logic [3:0]   out_key_type_o;
    logic [59:0]  out_key_id_o;
    logic [63:0]  out_addr_o;
    logic [127:0] out_data_o;
    logic [31:0]  out_size_o, item_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    cosim_log_item_assembler #(
        .XREG_W(64), .FREG_W(128), .DPI_W(32), .DEPTH(4), .KEY_TYPE_W(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_sof_i(in_sof_i),
        .in_kind_i(in_kind_i), .in_word_i(in_word_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_kind_o(out_kind_o), .out_key_type_o(out_key_type_o),
        .out_key_id_o(out_key_id_o), .out_addr_o(out_addr_o),
        .out_data_o(out_data_o), .out_size_o(out_size_o),
        .err_o(err_o), .item_cnt_o(item_cnt_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one word (inputs change 1 time unit after posedge) and returns after it is accepted.
    task automatic send(input logic sof, input logic [1:0] kind, input logic [31:0] w);
        logic acc;
        acc        = 1'b0;
        in_valid_i = 1'b1;
        in_sof_i   = sof;
        in_kind_i  = kind;
        in_word_i  = w;
        for (int i = 0; i < 200; i++) begin
            acc = in_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) break;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid_i = 1'b0;
        in_sof_i   = 1'b0;
    endtask

    task automatic send_reg(input logic [63:0] key, input logic [127:0] val);
        send(1'b1, 2'd0, key[31:0]);
        send(1'b0, 2'd0, key[63:32]);
        send(1'b0, 2'd0, val[31:0]);
        send(1'b0, 2'd0, val[63:32]);
        send(1'b0, 2'd0, val[95:64]);
        send(1'b0, 2'd0, val[127:96]);
    endtask

    task automatic send_mem(input logic [1:0] kind, input logic [63:0] addr,
                            input logic [63:0] data, input logic [31:0] size);
        send(1'b1, kind, addr[31:0]);
        send(1'b0, kind, addr[63:32]);
        send(1'b0, kind, data[31:0]);
        send(1'b0, kind, data[63:32]);
        send(1'b0, kind, size);
    endtask

    // Waits for a record, compares every field, then consumes it.
    task automatic pop_check(input string tag, input logic [1:0] kind, input logic [3:0] kt,
                             input logic [59:0] kid, input logic [63:0] addr,
                             input logic [127:0] data, input logic [31:0] size);
        for (int i = 0; i < 50 && !out_valid_o; i++) begin
            @(posedge clk_i);
            #1;
        end
        check({tag, "_valid"}, out_valid_o, 1);
        check({tag, "_kind"}, out_kind_o, kind);
        check({tag, "_ktype"}, out_key_type_o, kt);
        check({tag, "_kid"}, out_key_id_o, kid);
        check({tag, "_addr"}, out_addr_o, addr);
        check({tag, "_data"}, out_data_o, data);
        check({tag, "_size"}, out_size_o, size);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_sof_i    = 1'b0;
        in_kind_i   = 2'd0;
        in_word_i   = '0;
        out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        // 1: reset state
        check("rst_valid", out_valid_o, 0);
        check("rst_ready", in_ready_o, 1);
        check("rst_cnt", item_cnt_o, 0);
        check("rst_err", err_o, 0);
        check("rst_data", out_data_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 2: REG item, latency of one cycle after the last word
        send(1'b1, 2'd0, 32'h0000_0005);
        send(1'b0, 2'd0, 32'h1000_0000);
        send(1'b0, 2'd0, 32'h1111_1111);
        send(1'b0, 2'd0, 32'h2222_2222);
        send(1'b0, 2'd0, 32'h0);
        check("t2_notyet", out_valid_o, 0);
        send(1'b0, 2'd0, 32'h0);
        check("t2_latency", out_valid_o, 1);
        check("t2_cnt", item_cnt_o, 1);
        check("t2_err", err_o, 0);
        pop_check("t2", 2'd0, 4'd1, 60'd5, 64'd0, 128'h2222_2222_1111_1111, 32'd0);
        check("t2_empty", out_valid_o, 0);

        // 3: MEM_WR item
        send_mem(2'd2, 64'h8000_0000_0000_1000, 64'h0000_0000_DEAD_BEEF, 32'd4);
        check("t3_cnt", item_cnt_o, 2);
        pop_check("t3", 2'd2, 4'd0, 60'd0, 64'h8000_0000_0000_1000, 128'hDEAD_BEEF, 32'd4);

        // 4: back-pressure with DEPTH records held
        for (int k = 0; k < 4; k++)
            send_reg({4'd2, 60'(k + 10)}, 128'(k) * 128'h0101);
        check("t4_full", in_ready_o, 0);
        check("t4_cnt", item_cnt_o, 6);
        fork
            send(1'b1, 2'd0, 32'd20);
            begin
                repeat (4) begin
                    check("t4_stall", in_ready_o, 0);
                    @(posedge clk_i);
                    #1;
                end
                pop_check("t4_r0", 2'd0, 4'd2, 60'd10, 64'd0, 128'h0, 32'd0);
            end
        join
        send(1'b0, 2'd0, 32'h2000_0000);
        send(1'b0, 2'd0, 32'hAAAA_0000);
        send(1'b0, 2'd0, 32'h0);
        send(1'b0, 2'd0, 32'h0);
        send(1'b0, 2'd0, 32'h0);
        check("t4_full2", in_ready_o, 0);
        pop_check("t4_r1", 2'd0, 4'd2, 60'd11, 64'd0, 128'h0101, 32'd0);
        pop_check("t4_r2", 2'd0, 4'd2, 60'd12, 64'd0, 128'h0202, 32'd0);
        pop_check("t4_r3", 2'd0, 4'd2, 60'd13, 64'd0, 128'h0303, 32'd0);
        pop_check("t4_r4", 2'd0, 4'd2, 60'd20, 64'd0, 128'hAAAA_0000, 32'd0);
        check("t4_cnt2", item_cnt_o, 7);

        // 5: framing errors
        send(1'b0, 2'd0, 32'h55);
        check("t5_stray_err", err_o, 1);
        send(1'b1, 2'd0, 32'h1);
        check("t5_err_clear", err_o, 0);
        send(1'b0, 2'd0, 32'h2);
        send(1'b0, 2'd0, 32'h3);
        send(1'b1, 2'd1, 32'h0000_2000);
        check("t5_trunc_err", err_o, 1);
        send(1'b0, 2'd1, 32'h0);
        check("t5_err_pulse", err_o, 0);
        send(1'b0, 2'd1, 32'h1234_5678);
        send(1'b0, 2'd1, 32'h9ABC_DEF0);
        send(1'b0, 2'd1, 32'd8);
        check("t5_cnt", item_cnt_o, 8);
        pop_check("t5_rd", 2'd1, 4'd0, 60'd0, 64'h2000, 128'h9ABC_DEF0_1234_5678, 32'd8);
        send(1'b1, 2'd3, 32'h0);
        check("t5_ill_err", err_o, 1);
        for (int k = 0; k < 4; k++) begin
            send(1'b0, 2'd0, 32'(k));
            check("t5_drop_err", err_o, 0);
        end
        check("t5_drop_valid", out_valid_o, 0);
        check("t5_drop_cnt", item_cnt_o, 8);

        // 6: pop and push in the same cycle, then reset mid-item
        for (int k = 0; k < 4; k++)
            send_reg({4'd3, 60'(k)}, 128'(k + 1));
        check("t6_full", in_ready_o, 0);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check("t6_room", in_ready_o, 1);
        send(1'b1, 2'd0, 32'd7);
        send(1'b0, 2'd0, 32'h3000_0000);
        send(1'b0, 2'd0, 32'h77);
        send(1'b0, 2'd0, 32'h0);
        send(1'b0, 2'd0, 32'h0);
        out_ready_i = 1'b1;
        send(1'b0, 2'd0, 32'h0);
        out_ready_i = 1'b0;
        check("t6_same_occ", in_ready_o, 1);
        check("t6_cnt", item_cnt_o, 13);
        send_reg({4'd3, 60'd9}, 128'h99);
        check("t6_refull", in_ready_o, 0);
        pop_check("t6_r2", 2'd0, 4'd3, 60'd2, 64'd0, 128'd3, 32'd0);
        send(1'b1, 2'd2, 32'h4444);
        send(1'b0, 2'd2, 32'h0);
        #3 rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", out_valid_o, 0);
        check("t6_rst_ready", in_ready_o, 1);
        check("t6_rst_cnt", item_cnt_o, 0);
        check("t6_rst_err", err_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        send(1'b0, 2'd2, 32'h0);
        check("t6_post_stray", err_o, 1);
        send_mem(2'd1, 64'h10, 64'h20, 32'd2);
        check("t6_post_cnt", item_cnt_o, 1);
        pop_check("t6_post", 2'd1, 4'd0, 60'd0, 64'h10, 128'h20, 32'd2);
        check("t6_post_empty", out_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
